// File: rtl/neighbor_table_update_if.sv
// Advertisement handshake, routing-memory port and completion report of neighbor_table_update.
// The block owns the memory port while busy, so it takes the master side.
interface neighbor_table_update_if;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [15:0] pkt_neighbor_id;
    logic [15:0] pkt_cluster_id;
    logic [15:0] pkt_battery;
    logic [15:0] pkt_qvalue;
    logic [10:0] mem_address;
    logic        mem_wr_en;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        done;
    logic [1:0]  status;
    logic [5:0]  entry_index;

    modport master (
        input  pkt_valid, pkt_neighbor_id, pkt_cluster_id, pkt_battery, pkt_qvalue,
        input  mem_data_out,
        output pkt_ready, mem_address, mem_wr_en, mem_data_in,
        output done, status, entry_index
    );

    modport slave (
        output pkt_valid, pkt_neighbor_id, pkt_cluster_id, pkt_battery, pkt_qvalue,
        output mem_data_out,
        input  pkt_ready, mem_address, mem_wr_en, mem_data_in,
        input  done, status, entry_index
    );
endinterface

// File: rtl/neighbor_table_update.sv
// Neighbour-table writer: searches the neighbour ID list for a received advertisement and
// either refreshes the matching entry or appends a new one, bumping neighborCount last.
module neighbor_table_update #(
    parameter int          MAX_NEIGHBORS = 64,
    parameter logic [10:0] NID_BASE      = 11'h048,
    parameter logic [10:0] CID_BASE      = 11'h0C8,
    parameter logic [10:0] BAT_BASE      = 11'h148,
    parameter logic [10:0] QV_BASE       = 11'h1C8,
    parameter logic [10:0] NCOUNT_ADDR   = 11'h68A
) (
    input logic                     clock,
    input logic                     reset,
    neighbor_table_update_if.master bus
);
    localparam int IDX_W = 6;
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_NEIGHBORS);

    typedef enum logic [3:0] {
        IDLE, RD_COUNT, SEARCH, WR_NID, WR_CID, WR_BAT, WR_Q, WR_COUNT, DONE
    } state_t;

    state_t state, next_state;

    logic [15:0]      cap_id, cap_cid, cap_bat, cap_q;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             hit;
    logic [1:0]       status_r, next_status;
    logic [IDX_W-1:0] index_r, next_index;
    logic [CNT_W-1:0] rd_count;
    logic             id_match, last_entry, table_full;

    // A corrupted count word above capacity is treated as a full table.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [15:0] raw);
        if (raw > 16'(MAX_NEIGHBORS)) return CNT_MAX;
        return raw[CNT_W-1:0];
    endfunction

    function automatic logic [10:0] entry_addr(input logic [10:0] base, input logic [IDX_W-1:0] i);
        return base + 11'({i, 1'b0});
    endfunction

    assign rd_count        = clamp_count(bus.mem_data_out);
    assign id_match        = (bus.mem_data_out == cap_id);
    assign last_entry      = ({1'b0, idx} == cnt - CNT_W'(1));
    assign table_full      = (cnt == CNT_MAX);
    assign bus.status      = status_r;
    assign bus.entry_index = index_r;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state      = state;
        next_status     = status_r;
        next_index      = index_r;
        bus.pkt_ready   = 1'b0;
        bus.mem_address = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_data_in = '0;
        bus.done        = 1'b0;
        unique case (state)
            IDLE: begin
                bus.pkt_ready = 1'b1;
                if (bus.pkt_valid) next_state = RD_COUNT;
            end
            RD_COUNT: begin
                bus.mem_address = NCOUNT_ADDR;
                next_state      = (rd_count == '0) ? WR_NID : SEARCH;
            end
            SEARCH: begin
                bus.mem_address = entry_addr(NID_BASE, idx);
                if (id_match) begin
                    next_state = WR_CID;
                end else if (last_entry) begin
                    if (table_full) begin
                        next_state  = DONE;
                        next_status = 2'b11;
                        next_index  = '0;
                    end else begin
                        next_state = WR_NID;
                    end
                end
            end
            WR_NID: begin
                bus.mem_address = entry_addr(NID_BASE, idx);
                bus.mem_wr_en   = 1'b1;
                bus.mem_data_in = cap_id;
                next_state      = WR_CID;
            end
            WR_CID: begin
                bus.mem_address = entry_addr(CID_BASE, idx);
                bus.mem_wr_en   = 1'b1;
                bus.mem_data_in = cap_cid;
                next_state      = WR_BAT;
            end
            WR_BAT: begin
                bus.mem_address = entry_addr(BAT_BASE, idx);
                bus.mem_wr_en   = 1'b1;
                bus.mem_data_in = cap_bat;
                next_state      = WR_Q;
            end
            WR_Q: begin
                bus.mem_address = entry_addr(QV_BASE, idx);
                bus.mem_wr_en   = 1'b1;
                bus.mem_data_in = cap_q;
                if (hit) begin
                    next_state  = DONE;
                    next_status = 2'b01;
                    next_index  = idx;
                end else begin
                    next_state = WR_COUNT;
                end
            end
            // Count is written last so an aborted append never becomes visible.
            WR_COUNT: begin
                bus.mem_address = NCOUNT_ADDR;
                bus.mem_wr_en   = 1'b1;
                bus.mem_data_in = 16'(cnt) + 16'd1;
                next_state      = DONE;
                next_status     = 2'b10;
                next_index      = idx;
            end
            DONE: begin
                bus.done   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cap_id   <= '0;
            cap_cid  <= '0;
            cap_bat  <= '0;
            cap_q    <= '0;
            cnt      <= '0;
            idx      <= '0;
            hit      <= 1'b0;
            status_r <= 2'b00;
            index_r  <= '0;
        end else begin
            status_r <= next_status;
            index_r  <= next_index;
            case (state)
                IDLE: begin
                    if (bus.pkt_valid) begin
                        cap_id  <= bus.pkt_neighbor_id;
                        cap_cid <= bus.pkt_cluster_id;
                        cap_bat <= bus.pkt_battery;
                        cap_q   <= bus.pkt_qvalue;
                        hit     <= 1'b0;
                    end
                end
                RD_COUNT: begin
                    cnt <= rd_count;
                    idx <= '0;
                end
                // The first (lowest index) match stops the scan.
                SEARCH: begin
                    if (id_match) begin
                        hit <= 1'b1;
                    end else if (last_entry) begin
                        if (!table_full) idx <= cnt[IDX_W-1:0];
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
